iiitb_bc_mod: RTL

Parametrised modulo up/down binary counter, successor to the fixed 4-bit up/down counter. Adds configurable width and modulus, count enable with a clock-divide prescaler, synchronous parallel load, wrap or saturate mode, and terminal-count and wrap status outputs. Used as a general event/timebase counter wherever the design previously instantiated the fixed 4-bit counter.

---
 rtl/iiitb_bc_pkg.sv | 16 +
 rtl/iiitb_bc_prescale.sv | 49 ++++
 rtl/iiitb_bc_mod.sv | 89 ++++++++
 3 files changed

// File: rtl/iiitb_bc_pkg.sv
`default_nettype none
// ==========================================================================
// iiitb_bc_pkg : shared constants and load clamp for the modulo counter
// rev 1.0
// ==========================================================================
package iiitb_bc_pkg;
    localparam logic        DIR_UP    = 1'b1;
    localparam logic        DIR_DOWN  = 1'b0;
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction
endpackage
`default_nettype wire

// File: rtl/iiitb_bc_prescale.sv
`default_nettype none
// ==========================================================================
// iiitb_bc_prescale : enable-gated clock divider, one tick per PRESCALE
// enabled cycles.  rev 1.0
// ==========================================================================
module iiitb_bc_prescale #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic Clk,
    input  logic reset,
    input  logic En,
    input  logic clr,
    output logic tick
);
    generate
        if (PRESCALE == 1) begin : g_bypass
            // No phase state to keep; the remaining inputs are intentionally idle.
            logic unused_bypass;
            assign unused_bypass = Clk ^ reset ^ clr;
            assign tick          = En;
        end else begin : g_div
            localparam int unsigned    PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;

            always_comb begin
                phase_d = phase_q;
                if (clr) begin
                    phase_d = '0;
                end else if (En) begin
                    phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
                end
            end

            always_ff @(posedge Clk) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign tick = En && (phase_q == LAST);
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/iiitb_bc_mod.sv
`default_nettype none
// ==========================================================================
// iiitb_bc_mod : parametrised modulo up/down counter with prescaler, load,
// wrap/saturate mode and terminal-count / wrap status.  rev 1.0
// ==========================================================================
module iiitb_bc_mod
    import iiitb_bc_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Wrap
);
    // Load clamp works in 32 bits, so widths are capped at 31.
    generate
        if (WIDTH < 1 || WIDTH > 31 || MAX_VAL < 1 || 64'(MAX_VAL) >= (64'd1 << WIDTH) ||
            PRESCALE < 1 || (SATURATE != MODE_WRAP && SATURATE != MODE_SAT)) begin : g_param_check
            $error("iiitb_bc_mod: parameter out of range");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    iiitb_bc_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .Clk   (Clk),
        .reset (reset),
        .En    (En),
        .clr   (Load),
        .tick  (tick)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Load) begin
            count_d = WIDTH'(clamp_load(32'(LoadVal), MAX_VAL));
        end else if (tick) begin
            if (UpOrDown == DIR_UP) begin
                if (count_q != MAXV) begin
                    count_d = count_q + 1'b1;
                end else if (SATURATE == MODE_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else if (SATURATE == MODE_WRAP) begin
                    count_d = MAXV;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Count = count_q;
    assign Wrap  = wrap_q;
    assign Tc    = ((UpOrDown == DIR_UP)   && (count_q == MAXV)) ||
                   ((UpOrDown == DIR_DOWN) && (count_q == '0));
endmodule
`default_nettype wire
